// File: rtl/reg_writeback_pkg.sv
// Shared types and constants for the register-file writeback stage.
package reg_wb_pkg;

  typedef enum logic [1:0] {
    SRC_ALU  = 2'b00,
    SRC_LOAD = 2'b01,
    SRC_LINK = 2'b10,
    SRC_NONE = 2'b11
  } wb_src_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    WRITE    = 2'd2
  } wb_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/reg_writeback_if.sv
// Upstream result, memory response and register-file write bundle.
interface reg_writeback_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_src;
  logic [4:0]  in_rd;
  logic [31:0] in_data;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        LdR;
  logic [4:0]  RD;
  logic [31:0] DataR;
  logic        load_err;

  modport master (
    output in_valid, in_src, in_rd, in_data, in_funct3, in_addr_lo,
    output mem_rvalid, mem_rdata,
    input  in_ready, LdR, RD, DataR, load_err
  );

  modport slave (
    input  in_valid, in_src, in_rd, in_data, in_funct3, in_addr_lo,
    input  mem_rvalid, mem_rdata,
    output in_ready, LdR, RD, DataR, load_err
  );
endinterface

// File: rtl/reg_writeback_load_extend.sv
// Combinational load formatter: selects byte/half/word from an aligned word,
// extends it, and flags misaligned or unsupported funct3 encodings.
module load_extend
  import reg_wb_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_data,
  output logic        o_err
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane select and extension
  always_comb begin
    w_byte = 8'h00;
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: w_byte = 8'h00;
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    o_data = 32'h0000_0000;
    o_err  = 1'b0;
    case (i_funct3)
      F3_LB:  o_data = {{24{w_byte[7]}}, w_byte};
      F3_LBU: o_data = {24'h00_0000, w_byte};
      F3_LH: begin
        if (i_addr_lo[0]) o_err  = 1'b1;
        else              o_data = {{16{w_half[15]}}, w_half};
      end
      F3_LHU: begin
        if (i_addr_lo[0]) o_err  = 1'b1;
        else              o_data = {16'h0000, w_half};
      end
      F3_LW: begin
        if (i_addr_lo != 2'b00) o_err  = 1'b1;
        else                    o_data = i_rdata;
      end
      default: o_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/reg_writeback.sv
// Writeback stage feeding the 32x32 register file write port.
// Optional forwarding outputs are built when REG_WB_BYPASS_EN is defined.
module reg_writeback
  import reg_wb_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter bit R_ZERO_SUPPRESS = 1'b1
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           clk_cpu,
  reg_writeback_if.slave bus
`ifdef REG_WB_BYPASS_EN
  ,
  output logic           byp_valid,
  output logic [4:0]     byp_rd,
  output logic [31:0]    byp_data
`endif
);

  wb_state_t       r_state, w_state_nxt;
  logic [4:0]      r_rd, w_rd_nxt;
  logic [XLEN-1:0] r_data, w_data_nxt;
  logic [2:0]      r_funct3, w_funct3_nxt;
  logic [1:0]      r_addr_lo, w_addr_lo_nxt;
  logic            r_ldr, w_ldr_nxt;
  logic            r_load_err, w_load_err_nxt;
  logic [31:0]     w_ld_data;
  logic            w_ld_err;

  function automatic logic wr_allowed(input logic [4:0] rd);
    return !(R_ZERO_SUPPRESS && (rd == 5'd0));
  endfunction

  load_extend u_load_extend (
    .i_funct3  (r_funct3),
    .i_addr_lo (r_addr_lo),
    .i_rdata   (bus.mem_rdata),
    .o_data    (w_ld_data),
    .o_err     (w_ld_err)
  );

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and next-output logic; everything holds while clk_cpu is low
  always_comb begin
    w_state_nxt    = r_state;
    w_rd_nxt       = r_rd;
    w_data_nxt     = r_data;
    w_funct3_nxt   = r_funct3;
    w_addr_lo_nxt  = r_addr_lo;
    w_ldr_nxt      = r_ldr;
    w_load_err_nxt = r_load_err;
    if (clk_cpu) begin
      w_ldr_nxt      = 1'b0;
      w_load_err_nxt = 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            w_rd_nxt      = bus.in_rd;
            w_funct3_nxt  = bus.in_funct3;
            w_addr_lo_nxt = bus.in_addr_lo;
            case (wb_src_t'(bus.in_src))
              SRC_ALU, SRC_LINK: begin
                w_data_nxt  = bus.in_data;
                w_ldr_nxt   = wr_allowed(bus.in_rd);
                w_state_nxt = WRITE;
              end
              SRC_LOAD: w_state_nxt = WAIT_MEM;
              SRC_NONE: w_state_nxt = IDLE;
              default:  w_state_nxt = IDLE;
            endcase
          end else begin
            w_state_nxt = IDLE;
          end
        end
        WAIT_MEM: begin
          // A faulting load returns straight to IDLE and leaves DataR untouched
          if (bus.mem_rvalid && w_ld_err) begin
            w_load_err_nxt = 1'b1;
            w_state_nxt    = IDLE;
          end else if (bus.mem_rvalid) begin
            w_data_nxt  = w_ld_data;
            w_ldr_nxt   = wr_allowed(r_rd);
            w_state_nxt = WRITE;
          end else begin
            w_state_nxt = WAIT_MEM;
          end
        end
        WRITE:   w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Captured transaction fields and registered write-port outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rd       <= 5'd0;
      r_data     <= '0;
      r_funct3   <= 3'b000;
      r_addr_lo  <= 2'b00;
      r_ldr      <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_rd       <= w_rd_nxt;
      r_data     <= w_data_nxt;
      r_funct3   <= w_funct3_nxt;
      r_addr_lo  <= w_addr_lo_nxt;
      r_ldr      <= w_ldr_nxt;
      r_load_err <= w_load_err_nxt;
    end
  end

  assign bus.in_ready = (r_state == IDLE);
  assign bus.LdR      = r_ldr;
  assign bus.RD       = r_rd;
  assign bus.DataR    = r_data;
  assign bus.load_err = r_load_err;

`ifdef REG_WB_BYPASS_EN
  assign byp_valid = (r_state == WRITE) && r_ldr;
  assign byp_rd    = r_rd;
  assign byp_data  = r_data;
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Directed plus randomized checks of reg_writeback against a transaction-level model.
module tb_reg_writeback;
  import reg_wb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic clk_cpu;
  reg_writeback_if bus();
`ifdef REG_WB_BYPASS_EN
  logic        byp_valid;
  logic [4:0]  byp_rd;
  logic [31:0] byp_data;
`endif

  always #5 clk = ~clk;

  reg_writeback dut (
    .CLK     (clk),
    .RST     (rst),
    .clk_cpu (clk_cpu),
    .bus     (bus)
`ifdef REG_WB_BYPASS_EN
    ,
    .byp_valid (byp_valid),
    .byp_rd    (byp_rd),
    .byp_data  (byp_data)
`endif
  );

  int n_pass   = 0;
  int n_fail   = 0;
  int n_checks = 0;
  logic [4:0]  m_rd;
  logic [31:0] m_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit ref_err(input logic [2:0] f3, input logic [1:0] alo);
    case (f3)
      3'b000, 3'b100: return 1'b0;
      3'b001, 3'b101: return alo[0];
      3'b010:         return alo != 2'b00;
      default:        return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] ref_val(input logic [2:0] f3, input logic [1:0] alo,
                                          input logic [31:0] word);
    logic [31:0] b, h;
    b = (word >> (8 * alo)) & 32'h0000_00FF;
    h = (word >> (16 * alo[1])) & 32'h0000_FFFF;
    case (f3)
      3'b000:  return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      3'b100:  return b;
      3'b001:  return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      3'b101:  return h;
      default: return word;
    endcase
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_ldr"},   32'(bus.LdR), 32'd0);
    check({tag, "_rdy"},   32'(bus.in_ready), 32'd1);
    check({tag, "_err"},   32'(bus.load_err), 32'd0);
    check({tag, "_rd"},    32'(bus.RD), 32'(m_rd));
    check({tag, "_data"},  bus.DataR, m_data);
`ifdef REG_WB_BYPASS_EN
    check({tag, "_bypv"},  32'(byp_valid), 32'd0);
`endif
  endtask

  task automatic simple_txn(input logic [1:0] src, input logic [4:0] rd, input logic [31:0] data);
    bus.in_valid = 1'b1; bus.in_src = src; bus.in_rd = rd; bus.in_data = data;
    bus.in_funct3 = 3'($urandom); bus.in_addr_lo = 2'($urandom);
    tick();
    bus.in_valid = 1'b0; bus.in_data = $urandom;
    m_rd = rd;
    if (src != SRC_NONE) begin
      m_data = data;
      check("wr_ldr",  32'(bus.LdR), (rd != 5'd0) ? 32'd1 : 32'd0);
      check("wr_rdy",  32'(bus.in_ready), 32'd0);
      check("wr_rd",   32'(bus.RD), 32'(rd));
      check("wr_data", bus.DataR, data);
      check("wr_err",  32'(bus.load_err), 32'd0);
`ifdef REG_WB_BYPASS_EN
      check("byp_valid", 32'(byp_valid), (rd != 5'd0) ? 32'd1 : 32'd0);
      check("byp_rd",    32'(byp_rd), 32'(rd));
      check("byp_data",  byp_data, data);
`endif
      tick();
    end
    check_idle("after_wr");
  endtask

  task automatic load_txn(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] alo,
                          input logic [31:0] word, input int delay);
    bus.in_valid = 1'b1; bus.in_src = SRC_LOAD; bus.in_rd = rd;
    bus.in_funct3 = f3; bus.in_addr_lo = alo; bus.in_data = $urandom;
    tick();
    bus.in_valid = 1'b0;
    m_rd = rd;
    check("ld_acc_rdy", 32'(bus.in_ready), 32'd0);
    check("ld_acc_ldr", 32'(bus.LdR), 32'd0);
    check("ld_acc_rd",  32'(bus.RD), 32'(rd));
    repeat (delay) begin
      bus.mem_rdata = $urandom;
      tick();
      check("ld_wait_rdy", 32'(bus.in_ready), 32'd0);
      check("ld_wait_ldr", 32'(bus.LdR), 32'd0);
    end
    bus.mem_rvalid = 1'b1; bus.mem_rdata = word;
    tick();
    bus.mem_rvalid = 1'b0; bus.mem_rdata = $urandom;
    if (ref_err(f3, alo)) begin
      check("ld_err_pulse", 32'(bus.load_err), 32'd1);
      check("ld_err_ldr",   32'(bus.LdR), 32'd0);
      check("ld_err_rdy",   32'(bus.in_ready), 32'd1);
      check("ld_err_data",  bus.DataR, m_data);
      tick();
      check_idle("ld_err_end");
    end else begin
      m_data = ref_val(f3, alo, word);
      check("ld_ldr",  32'(bus.LdR), (rd != 5'd0) ? 32'd1 : 32'd0);
      check("ld_data", bus.DataR, m_data);
      check("ld_rdy",  32'(bus.in_ready), 32'd0);
      check("ld_err",  32'(bus.load_err), 32'd0);
      tick();
      check_idle("ld_end");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; clk_cpu = 1'b1;
    bus.in_valid = 1'b0; bus.in_src = 2'b00; bus.in_rd = 5'd0; bus.in_data = 32'd0;
    bus.in_funct3 = 3'd0; bus.in_addr_lo = 2'd0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'd0;
    m_rd = 5'd0; m_data = 32'd0;
    #12;
    check("rst_ldr",  32'(bus.LdR), 32'd0);
    check("rst_rd",   32'(bus.RD), 32'd0);
    check("rst_data", bus.DataR, 32'd0);
    check("rst_err",  32'(bus.load_err), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_rdy", 32'(bus.in_ready), 32'd1);
    tick();

    simple_txn(SRC_ALU, 5'd5, 32'hDEAD_BEEF);
    load_txn(5'd7, F3_LB, 2'd3, 32'h80FF_1234, 3);
    check("lb_sign", bus.DataR, 32'hFFFF_FF80);
    load_txn(5'd8, F3_LBU, 2'd3, 32'h80FF_1234, 3);
    check("lbu_zero", bus.DataR, 32'h0000_0080);
    load_txn(5'd9, F3_LW, 2'd2, 32'h1234_5678, 0);
    simple_txn(SRC_ALU, 5'd0, 32'h0000_0001);
    simple_txn(SRC_LINK, 5'd1, 32'h0000_0104);
    simple_txn(SRC_NONE, 5'd3, 32'h5555_AAAA);

    // memory response outside WAIT_MEM must be ignored
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0BAD_0BAD;
    tick();
    bus.mem_rvalid = 1'b0;
    check_idle("stray_rvalid");

    // stall in WAIT_MEM
    bus.in_valid = 1'b1; bus.in_src = SRC_LOAD; bus.in_rd = 5'd10;
    bus.in_funct3 = F3_LW; bus.in_addr_lo = 2'd0;
    tick();
    bus.in_valid = 1'b0; m_rd = 5'd10;
    clk_cpu = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_wm_rdy", 32'(bus.in_ready), 32'd0);
      check("stall_wm_ldr", 32'(bus.LdR), 32'd0);
      check("stall_wm_err", 32'(bus.load_err), 32'd0);
    end
    clk_cpu = 1'b1;
    tick();
    bus.mem_rvalid = 1'b0;
    m_data = 32'hCAFE_F00D;
    check("stall_wm_ldr_go", 32'(bus.LdR), 32'd1);
    check("stall_wm_data",   bus.DataR, m_data);
    tick();
    check_idle("stall_wm_end");

    // stall in WRITE keeps the single write pending
    bus.in_valid = 1'b1; bus.in_src = SRC_ALU; bus.in_rd = 5'd12; bus.in_data = 32'hAAAA_5555;
    tick();
    bus.in_valid = 1'b0; m_rd = 5'd12; m_data = 32'hAAAA_5555;
    clk_cpu = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_wr_ldr", 32'(bus.LdR), 32'd1);
      check("stall_wr_rdy", 32'(bus.in_ready), 32'd0);
    end
    clk_cpu = 1'b1;
    tick();
    check_idle("stall_wr_end");

    // asynchronous reset during WRITE
    bus.in_valid = 1'b1; bus.in_src = SRC_ALU; bus.in_rd = 5'd13; bus.in_data = 32'h0000_0077;
    tick();
    bus.in_valid = 1'b0;
    check("arst_pre_ldr", 32'(bus.LdR), 32'd1);
    #2 rst = 1'b1;
    #1;
    m_rd = 5'd0; m_data = 32'd0;
    check_idle("arst");
    rst = 1'b0;
    tick();
    check_idle("arst_after");

    for (int t = 0; t < 40; t++) begin
      logic [1:0] src;
      src = 2'($urandom_range(0, 3));
      if (src == SRC_LOAD)
        load_txn(5'($urandom), 3'($urandom_range(0, 7)), 2'($urandom), $urandom,
                 int'($urandom_range(0, 3)));
      else
        simple_txn(src, 5'($urandom), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_writeback.md
Name: reg_writeback

Overview:
- Writeback stage directly upstream of the 32x32 register file.
- Accepts one retiring instruction result per transaction: ALU result, PC+4 link value, or a pending load.
- For loads, waits for memory read data, then extracts and sign- or zero-extends it.
- Drives the register-file write port (LdR/RD/DataR) for exactly one enabled cycle per instruction.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- R_ZERO_SUPPRESS, 1, when 1 no write is issued for RD==0.

Ports:
- CLK  in  1  system clock; all state changes on posedge CLK.
- RST  in  1  asynchronous, active-high reset.
- clk_cpu  in  1  CPU step enable; state advances only on posedge CLK with clk_cpu==1.
- in_valid  in  1  upstream result valid.
- in_ready  out  1  stage can accept; equals (state==IDLE).
- in_src  in  2  result source: 00 ALU, 01 LOAD, 10 LINK, 11 NONE (no write).
- in_rd  in  5  destination register.
- in_data  in  32  ALU result or PC+4.
- in_funct3  in  3  load size/sign, from the RV32I encoding.
- in_addr_lo  in  2  load byte address bits [1:0].
- mem_rvalid  in  1  load data valid, single-cycle pulse.
- mem_rdata  in  32  aligned memory word.
- LdR  out  1  register-file write enable.
- RD  out  5  register-file write index.
- DataR  out  32  register-file write data.
- load_err  out  1  one-cycle pulse on a misaligned or illegal-funct3 load.

Behaviour:
- Reset values:
  - State is IDLE.
  - LdR=0, RD=0, DataR=0, load_err=0.
  - in_ready=1 once reset deasserts.
- Clock gating: all transitions below also require clk_cpu==1. With clk_cpu==0 every register holds.
- FSM states: IDLE, WAIT_MEM, WRITE.
- IDLE:
  - A transfer occurs when in_valid&in_ready.
  - Captures in_rd, in_src, in_funct3 and in_addr_lo.
  - src ALU/LINK: DataR<=in_data, go to WRITE.
  - src LOAD: go to WAIT_MEM.
  - src NONE: stay IDLE, no write.
- WAIT_MEM:
  - On mem_rvalid, format mem_rdata into DataR and go to WRITE.
  - mem_rvalid seen in IDLE or WRITE is ignored.
- Load formatting:
  - 000 LB: byte at addr_lo, sign-extended.
  - 100 LBU: byte at addr_lo, zero-extended.
  - 001 LH: half at addr_lo[1], sign-extended.
  - 101 LHU: half at addr_lo[1], zero-extended.
  - 010 LW: full word.
- Load errors:
  - Triggered by LH/LHU with addr_lo[0]==1, LW with addr_lo!=0, or any other funct3.
  - Response: pulse load_err for one cycle on the mem_rvalid cycle, suppress the write, return to IDLE.
- WRITE:
  - LdR=1 for exactly one enabled cycle, then IDLE.
  - RD and DataR stay stable through the WRITE cycle and hold their values afterwards.
  - If R_ZERO_SUPPRESS and RD==0, LdR stays 0 but the state still passes through WRITE.
- Latency from accept to LdR:
  - ALU/LINK: 1 enabled cycle.
  - LOAD: 1 enabled cycle after the mem_rvalid cycle.
- Throughput: at most one result per 2 enabled cycles, because in_ready is low during WRITE.
- Mid-operation reset: RST asserted in WAIT_MEM or WRITE forces IDLE immediately and drops LdR asynchronously. The pending write is lost.
- The register file samples on the following negedge, so no combinational path from in_* to LdR/RD/DataR exists.

Optional Feature:
- Macro: REG_WB_BYPASS_EN.
- When defined, the block adds ports byp_valid out 1, byp_rd out 5 and byp_data out 32.
  - These are combinationally equal to (state==WRITE && LdR), RD and DataR.
  - Decode uses them to forward a value being written this cycle that the register file's registered read would return stale.
- When undefined, these ports do not exist and no forwarding logic is built.

Decomposition:
- Package reg_wb_pkg:
  - enum wb_src_t {SRC_ALU, SRC_LOAD, SRC_LINK, SRC_NONE}.
  - enum wb_state_t {IDLE, WAIT_MEM, WRITE}.
  - funct3 constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
- Sub-module load_extend: purely combinational.
  - Inputs funct3, addr_lo, rdata.
  - Outputs formatted data and an err flag.
  - Instantiated once.

Test Plan:
- ALU write: src=ALU, rd=5, data=0xDEADBEEF accepted -> next enabled cycle LdR=1, RD=5, DataR=0xDEADBEEF; in_ready=0 that cycle, then 1.
- LB sign: src=LOAD, funct3=000, addr_lo=3, three-cycle delay then mem_rdata=0x80FF_1234 -> DataR=0xFFFFFF80, LdR one cycle after mem_rvalid; the LBU variant gives 0x00000080.
- Misaligned LW: funct3=010, addr_lo=2, mem_rvalid -> load_err pulses 1 cycle, LdR never asserts, back to IDLE.
- x0 suppression: src=ALU, rd=0, data=0x1 -> LdR stays 0, in_ready low one cycle.
- Stall/reset:
  - clk_cpu held 0 for 4 cycles in WAIT_MEM -> no state change.
  - RST pulse in WRITE -> LdR falls without a clock edge, state IDLE, outputs 0.
- Bypass (with REG_WB_BYPASS_EN): src=LINK, rd=1, data=0x104 -> byp_valid=1, byp_rd=1, byp_data=0x104 in the WRITE cycle only.
